pred_multi: RTL and testbench
=============================

// Module: pred_multi
// PURPOSE
//  Multi-channel edge-delay (phase predictor) for the DRSSTC gate path. Each channel
//  re-times an asynchronous feedback signal, delaying rising and falling edges by
//  independent programmable clock counts. Pulses shorter than the programmed delay
//  are rejected and flagged. Sits between the feedback comparator inputs and gate logic.
// PARAMETERS
//  CH          2   number of independent channels
//  W           8   delay counter / shift word width (max delay 2^W-1 clocks)
//  SYNC_STAGES 2   CDC flip-flop stages per channel input (>=2)
// PORTS
//  clk         in   1     system clock
//  rst         in   1     asynchronous, active-high reset
//  sgn         in   CH    raw asynchronous input, one bit per channel
//  en          in   CH    per-channel enable (synchronous to clk)
//  shift_rise  in   CH*W  rising-edge delay, channel i at [i*W +: W]
//  shift_fall  in   CH*W  falling-edge delay, channel i at [i*W +: W]
//  sgn_pre     out  CH    delayed/filtered output
//  busy        out  CH    1 while channel counts a pending edge
//  edge_drop   out  CH    1-clock pulse when a pending edge is cancelled
// BEHAVIOUR
//  - Reset (async, rst=1): sgn_pre=0, busy=0, edge_drop=0, counters=0, sync regs=0,
//    FSM=IDLE, all channels. Release takes effect at the next clk edge.
//  - Per channel: sgn passes SYNC_STAGES flops -> sgn_s. Sync chain runs regardless of en.
//  - FSM states IDLE, COUNT. busy = (state==COUNT), registered.
//  - IDLE: if sgn_s != sgn_pre: load cnt = sgn_s ? shift_rise : shift_fall, go COUNT.
//  - COUNT, priority order:
//    1) sgn_s == sgn_pre (input reverted): go IDLE, edge_drop=1 one clock, sgn_pre held.
//    2) cnt == 0: sgn_pre <= sgn_s, go IDLE.
//    3) else cnt <= cnt - 1.
//  - Latency: sgn_pre changes exactly S+1 clocks after sgn_s changes (S = loaded shift);
//    S=0 -> 1 clock. Raw-input-to-output: SYNC_STAGES+S+1 clocks (+0/1 async sampling).
//  - Shift value latched at load; changing shift_* during COUNT has no effect on that edge.
//  - Pulse shorter than S+1 clocks (at sgn_s) never reaches sgn_pre; exactly S+1 passes.
//  - Revert and cnt==0 in the same cycle: revert wins (edge dropped).
//  - Back-to-back: after edge commit, next opposite edge loads on the following clock.
//  - en=0 (synchronous, overrides FSM): sgn_pre<=0, state<=IDLE, cnt<=0, no edge_drop.
//    On en 0->1 with sgn_s=1, a normal rising-edge delay starts (shift_rise).
//  - rst mid-count: immediate return to reset values; pending edge discarded, no pulse.
//  - Counter is W bits, decrement only from nonzero; no wrap-around possible.
//  - Channels fully independent; no shared state.
// STRUCTURE
//  - pred_pkg: typedef logic [W-1:0] shift_t; enum {IDLE, COUNT} pred_state_e;
//    SYNC_STAGES default constant.
//  - Sub-module pred_chan (one channel: sync chain + FSM + counter), instanced CH times
//    in a generate loop; top does only port slicing.
//  - Existing sync block reused inside pred_chan for the CDC stages.
// TESTING
//  - Reset: rst=1 with sgn=all 1 -> sgn_pre=0, busy=0, edge_drop=0; hold after release
//    until sync + delay elapses.
//  - Basic delay: ch0 shift_rise=5, shift_fall=2; sgn[0] 0->1 held -> sgn_pre[0] rises
//    6 clks after sgn_s; 1->0 -> falls 3 clks after sgn_s; busy high exactly during counts.
//  - Glitch reject: shift_rise=10, 4-clk high pulse -> sgn_pre stays 0, edge_drop one
//    1-clk pulse; pulse of exactly 11 clks at sgn_s -> passes.
//  - Zero shift / max shift: shift=0 -> 1-clk latency; shift=255 (W=8) -> 256-clk latency.
//  - Mid-count changes: change shift_rise 5->20 during count -> still 6 clks; en=0 mid-count
//    -> sgn_pre=0 next clk, busy=0, no edge_drop; rst mid-count -> all outputs 0.
//  - Channel independence (CH=4): different shifts and overlapping edges per channel ->
//    each output matches its own reference model; no cross-talk.

Source files
------------

// File: rtl/pred_pkg.sv
// Shared types and defaults for the multi-channel edge-delay predictor.
package pred_pkg;

  // Default delay word width and synchroniser depth.
  localparam int PRED_W           = 8;
  localparam int PRED_SYNC_STAGES = 2;

  // Programmed delay word at the default width.
  typedef logic [PRED_W-1:0] shift_t;

  // Per-channel edge FSM: waiting for an edge, or timing a pending edge.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } pred_state_e;

endpackage

// File: rtl/pred_chan.sv
// One predictor channel: synchroniser, edge FSM and delay counter.
// An edge on the synchronised input reaches sgn_pre exactly S+1 clocks later,
// where S is the rise or fall delay captured when the edge was detected.
module pred_chan
  import pred_pkg::*;
#(
  parameter int W           = PRED_W,
  parameter int SYNC_STAGES = PRED_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sgn,
  input  logic         en,
  input  logic [W-1:0] shift_rise,
  input  logic [W-1:0] shift_fall,
  output logic         sgn_pre,
  output logic         busy,
  output logic         edge_drop
);

  logic         sgn_s;
  logic [W-1:0] shift_sel;
  logic [W-1:0] cnt;
  pred_state_e  state;

  pred_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (sgn),
    .q  (sgn_s)
  );

  // Delay that applies to the edge currently presented by the synchroniser.
  assign shift_sel = sgn_s ? shift_rise : shift_fall;

  // Edge FSM. The detection clock is the first of the S+1 delay clocks, so the
  // counter is loaded with S-1 and a zero delay commits on the detection clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sgn_pre   <= 1'b0;
      busy      <= 1'b0;
      edge_drop <= 1'b0;
    end else begin
      edge_drop <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        cnt     <= '0;
        sgn_pre <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sgn_s != sgn_pre) begin
              if (shift_sel == '0) begin
                sgn_pre <= sgn_s;
              end else begin
                cnt   <= shift_sel - W'(1);
                state <= COUNT;
                busy  <= 1'b1;
              end
            end
          end
          COUNT: begin
            if (sgn_s == sgn_pre) begin
              // Input reverted before the delay expired: cancel the edge.
              state     <= IDLE;
              busy      <= 1'b0;
              edge_drop <= 1'b1;
            end else if (cnt == '0) begin
              sgn_pre <= sgn_s;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              cnt <= cnt - W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pred_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
module pred_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pred_multi.sv
// Multi-channel edge-delay (phase predictor) for the gate-drive feedback path.
// Each channel is fully independent; this level only slices the buses.
module pred_multi
  import pred_pkg::*;
#(
  parameter int CH          = 2,
  parameter int W           = PRED_W,
  parameter int SYNC_STAGES = PRED_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   sgn,
  input  logic [CH-1:0]   en,
  input  logic [CH*W-1:0] shift_rise,
  input  logic [CH*W-1:0] shift_fall,
  output logic [CH-1:0]   sgn_pre,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   edge_drop
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    pred_chan #(
      .W          (W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .sgn       (sgn[i]),
      .en        (en[i]),
      .shift_rise(shift_rise[i*W +: W]),
      .shift_fall(shift_fall[i*W +: W]),
      .sgn_pre   (sgn_pre[i]),
      .busy      (busy[i]),
      .edge_drop (edge_drop[i])
    );
  end

endmodule

// File: tb/tb_pred_multi.sv
// Bench for pred_multi: directed delay table, multi-cycle corner sequences and
// randomized multi-channel traffic compared against a deadline-based model.
module tb_pred_multi;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   sgn = '1;
  logic [CH-1:0]   en  = '1;
  logic [CH*W-1:0] shift_rise = '0;
  logic [CH*W-1:0] shift_fall = '0;
  logic [CH-1:0]   sgn_pre;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   edge_drop;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  pred_multi #(
    .CH(CH),
    .W(W),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sgn       (sgn),
    .en        (en),
    .shift_rise(shift_rise),
    .shift_fall(shift_fall),
    .sgn_pre   (sgn_pre),
    .busy      (busy),
    .edge_drop (edge_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_shift(input int c, input int r, input int f);
    logic [31:0] rv, fv;
    rv = r;
    fv = f;
    shift_rise[c*W +: W] = rv[W-1:0];
    shift_fall[c*W +: W] = fv[W-1:0];
  endtask

  // Reference model: an edge seen at the synchronised input is scheduled with
  // an absolute deadline S clocks after detection; it is dropped if the input
  // returns to the committed level first. The synchronised input lags the raw
  // input sampled at an edge by two clocks.
  logic [CH-1:0] m_pre = '0, m_busy = '0, m_drop = '0;
  logic [CH-1:0] h1 = '0, h2 = '0;
  int            m_due[CH];
  int            cyc = 0;
  logic          ms;
  int            msh;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre  = '0;
      m_busy = '0;
      m_drop = '0;
      h1     = '0;
      h2     = '0;
    end else begin
      cyc++;
      for (int c = 0; c < CH; c++) begin
        ms = h2[c];
        m_drop[c] = 1'b0;
        if (!en[c]) begin
          m_pre[c]  = 1'b0;
          m_busy[c] = 1'b0;
        end else if (m_busy[c]) begin
          if (ms == m_pre[c]) begin
            m_busy[c] = 1'b0;
            m_drop[c] = 1'b1;
          end else if (cyc == m_due[c]) begin
            m_pre[c]  = ms;
            m_busy[c] = 1'b0;
          end
        end else if (ms != m_pre[c]) begin
          msh = ms ? int'(shift_rise[c*W +: W]) : int'(shift_fall[c*W +: W]);
          if (msh == 0) m_pre[c] = ms;
          else begin
            m_busy[c] = 1'b1;
            m_due[c]  = cyc + msh;
          end
        end
      end
      h2 = h1;
      h1 = sgn;
    end
  end

  // Continuous comparison of every channel against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_sgn_pre", 32'(sgn_pre), 32'(m_pre));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_edge_drop", 32'(edge_drop), 32'(m_drop));
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    int rise;
    int fall;
    int hi;
    int exp_rk;
    int exp_fk;
    int exp_drop;
    int exp_busy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int rk, fk, drops, busyc;

    // raw-input-to-output latency is S+3 clocks (2 sync flops + S + 1)
    tbl[0] = '{5, 2, 20, 8, 25, 0, 7};
    tbl[1] = '{0, 0, 10, 3, 13, 0, 0};
    tbl[2] = '{255, 255, 300, 258, 558, 0, 510};
    tbl[3] = '{10, 1, 4, 0, 0, 1, 4};
    tbl[4] = '{10, 1, 11, 13, 15, 0, 11};
    tbl[5] = '{10, 1, 10, 0, 0, 1, 10};
    tbl[6] = '{3, 3, 1, 0, 0, 1, 1};

    // Reset with all inputs high
    for (int c = 0; c < CH; c++) set_shift(c, 5, 5);
    repeat (3) @(negedge clk);
    chk("rst_sgn_pre", 32'(sgn_pre), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_edge_drop", 32'(edge_drop), 0);
    #2 rst = 1'b0;
    chk_on = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) chk("post_rst_hold", 32'(sgn_pre), 0);
      if (k == 8) chk("post_rst_rise", 32'(sgn_pre), 32'hF);
    end
    sgn = '0;
    repeat (20) @(negedge clk);

    // Table-driven delay / glitch vectors on channel 0
    for (int i = 0; i < 7; i++) begin
      set_shift(0, tbl[i].rise, tbl[i].fall);
      repeat (4) @(negedge clk);
      rk = 0; fk = 0; drops = 0; busyc = 0;
      sgn[0] = 1'b1;
      for (int k = 1; k <= tbl[i].hi + 300; k++) begin
        @(negedge clk);
        if (sgn_pre[0] && rk == 0) rk = k;
        if (!sgn_pre[0] && rk != 0 && fk == 0) fk = k;
        drops += int'(edge_drop[0]);
        busyc += int'(busy[0]);
        if (k == tbl[i].hi) sgn[0] = 1'b0;
      end
      chk($sformatf("tbl%0d_rise_clk", i), rk, tbl[i].exp_rk);
      chk($sformatf("tbl%0d_fall_clk", i), fk, tbl[i].exp_fk);
      chk($sformatf("tbl%0d_drops", i), drops, tbl[i].exp_drop);
      chk($sformatf("tbl%0d_busy_clks", i), busyc, tbl[i].exp_busy);
    end

    // Shift change during count does not affect the pending edge (channel 1)
    set_shift(1, 5, 0);
    @(negedge clk);
    sgn[1] = 1'b1;
    rk = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("midshift_busy", 32'(busy[1]), 1);
        set_shift(1, 20, 0);
      end
      if (sgn_pre[1] && rk == 0) rk = k;
    end
    chk("midshift_rise_clk", rk, 8);
    sgn[1] = 1'b0;
    repeat (10) @(negedge clk);

    // en=0 mid-count clears the channel without a drop pulse (channel 2)
    set_shift(2, 20, 2);
    @(negedge clk);
    sgn[2] = 1'b1;
    repeat (6) @(negedge clk);
    chk("en_pre_busy", 32'(busy[2]), 1);
    en[2] = 1'b0;
    @(negedge clk);
    chk("en_off_sgn_pre", 32'(sgn_pre[2]), 0);
    chk("en_off_busy", 32'(busy[2]), 0);
    chk("en_off_drop", 32'(edge_drop[2]), 0);
    en[2] = 1'b1;
    rk = 0; drops = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sgn_pre[2] && rk == 0) rk = k;
      drops += int'(edge_drop[2]);
    end
    chk("en_on_rise_clk", rk, 21);
    chk("en_drops", drops, 0);
    sgn[2] = 1'b0;
    repeat (10) @(negedge clk);

    // Async reset mid-count (channel 3)
    set_shift(3, 30, 3);
    @(negedge clk);
    sgn[3] = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_busy_before", 32'(busy[3]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_sgn_pre", 32'(sgn_pre), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_edge_drop", 32'(edge_drop), 0);
    sgn[3] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);

    // Randomized independent traffic on all channels
    for (int c = 0; c < CH; c++) set_shift(c, $urandom_range(12), $urandom_range(12));
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5) == 0) sgn[c] = ~sgn[c];
        if ($urandom_range(99) == 0) set_shift(c, $urandom_range(12), $urandom_range(12));
        if (en[c]) begin
          if ($urandom_range(299) == 0) en[c] = 1'b0;
        end else if ($urandom_range(9) == 0) en[c] = 1'b1;
      end
    end
    repeat (20) @(negedge clk);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
